// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream frame FIFO.
package axis_fifo_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FRAME,
        WR_DROP
    } wr_state_e;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/AXIS_IF.sv
// AXI-Stream bundle; Master drives the payload, Slave drives tready.
interface AXIS_IF #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned USER_W = 1
);
    localparam int unsigned KEEP_W = (DATA_W + 7) / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;
    logic              twakeup;

    modport Master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
        input  tready
    );

    modport Slave (
        input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM with registered, enable-gated read port.
module axis_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_fifo.sv
// AXI-Stream FIFO with optional store-and-forward frame mode and frame dropping.
module axis_frame_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned       DEPTH                = 1024,
    parameter int unsigned       DATA_W               = 8,
    parameter int unsigned       ID_W                 = 4,
    parameter int unsigned       DEST_W               = 4,
    parameter int unsigned       USER_W               = 1,
    parameter bit                FRAME_FIFO           = 1'b0,
    parameter bit                DROP_BAD_FRAME       = 1'b0,
    parameter bit                DROP_WHEN_FULL       = 1'b0,
    parameter logic [USER_W-1:0] USER_BAD_FRAME_VALUE = USER_W'(1'b1),
    parameter logic [USER_W-1:0] USER_BAD_FRAME_MASK  = USER_W'(1'b1),
    parameter int unsigned       ALMOST_FULL_LEVEL    = DEPTH - 4,
    parameter int unsigned       ALMOST_EMPTY_LEVEL   = 4,
    localparam int unsigned      PtrW                 = ptr_width(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    AXIS_IF.Slave           in_axis_if,
    AXIS_IF.Master          out_axis_if,
    output logic [PtrW-1:0] status_depth,
    output logic [PtrW-1:0] status_frame_count,
    output logic            status_almost_full,
    output logic            status_almost_empty,
    output logic            status_overflow,
    output logic            status_bad_frame,
    output logic            status_good_frame
);
    localparam int unsigned     AddrW   = PtrW - 1;
    localparam int unsigned     KeepW   = (DATA_W + 7) / 8;
    localparam int unsigned     WordW   = DATA_W + KeepW + 1 + ID_W + DEST_W + USER_W;
    localparam logic [PtrW-1:0] PtrMsb  = {1'b1, {AddrW{1'b0}}};
    localparam logic [PtrW-1:0] AfLevel = PtrW'(ALMOST_FULL_LEVEL);
    localparam logic [PtrW-1:0] AeLevel = PtrW'(ALMOST_EMPTY_LEVEL);

    wr_state_e       wr_state_q, wr_state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] frame_cnt_q, frame_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            run_q, run_d;

    logic [PtrW-1:0]  head_ptr;
    logic             full, frame_full, empty, bad_user;
    logic             in_ready, ram_we, rd_en, frame_inc, rd_last;
    logic [WordW-1:0] ram_rd_data;

    // The beat parked in the output register still occupies a slot.
    assign head_ptr   = rd_ptr_q - PtrW'(out_valid_q);
    assign full       = (wr_ptr_q ^ head_ptr) == PtrMsb;
    assign frame_full = (wr_ptr_q ^ commit_ptr_q) == PtrMsb;
    assign empty      = commit_ptr_q == rd_ptr_q;
    assign bad_user   = ((in_axis_if.tuser ^ USER_BAD_FRAME_VALUE) & USER_BAD_FRAME_MASK) == '0;

    always_comb begin
        wr_ptr_d          = wr_ptr_q;
        commit_ptr_d      = commit_ptr_q;
        wr_state_d        = wr_state_q;
        ram_we            = 1'b0;
        frame_inc         = 1'b0;
        status_overflow   = 1'b0;
        status_bad_frame  = 1'b0;
        status_good_frame = 1'b0;
        // A frame that fills the whole FIFO can never commit, so it is swallowed.
        if (FRAME_FIFO) begin
            in_ready = run_q && (!full || frame_full || DROP_WHEN_FULL || wr_state_q == WR_DROP);
        end else begin
            in_ready = run_q && !full;
        end
        if (in_axis_if.tvalid && in_ready) begin
            if (FRAME_FIFO && (wr_state_q == WR_DROP || full)) begin
                wr_ptr_d = commit_ptr_q;
                if (in_axis_if.tlast) begin
                    wr_state_d      = WR_IDLE;
                    status_overflow = 1'b1;
                end else begin
                    wr_state_d = WR_DROP;
                end
            end else begin
                ram_we     = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                wr_state_d = in_axis_if.tlast ? WR_IDLE : WR_FRAME;
                if (!FRAME_FIFO) begin
                    commit_ptr_d = wr_ptr_q + 1'b1;
                    frame_inc    = in_axis_if.tlast;
                end else if (in_axis_if.tlast) begin
                    if (DROP_BAD_FRAME && bad_user) begin
                        wr_ptr_d         = commit_ptr_q;
                        status_bad_frame = 1'b1;
                    end else begin
                        commit_ptr_d      = wr_ptr_q + 1'b1;
                        status_good_frame = 1'b1;
                        frame_inc         = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_en       = !empty && (!out_valid_q || out_axis_if.tready);
        rd_ptr_d    = rd_ptr_q + PtrW'(rd_en);
        out_valid_d = rd_en || (out_valid_q && !out_axis_if.tready);
        frame_cnt_d = frame_cnt_q + PtrW'(frame_inc)
                      - PtrW'(out_valid_q && out_axis_if.tready && rd_last);
        run_d       = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q   <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            frame_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_cnt_q  <= frame_cnt_d;
            out_valid_q  <= out_valid_d;
            run_q        <= run_d;
        end
    end

    axis_fifo_ram #(
        .WIDTH (WordW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[AddrW-1:0]),
        .wr_data_i ({in_axis_if.tdata, in_axis_if.tkeep, in_axis_if.tlast,
                     in_axis_if.tid, in_axis_if.tdest, in_axis_if.tuser}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AddrW-1:0]),
        .rd_data_o (ram_rd_data)
    );

    assign in_axis_if.tready = in_ready;

    assign {out_axis_if.tdata, out_axis_if.tkeep, rd_last,
            out_axis_if.tid, out_axis_if.tdest, out_axis_if.tuser} = ram_rd_data;
    assign out_axis_if.tlast   = rd_last;
    assign out_axis_if.tvalid  = out_valid_q;
    assign out_axis_if.tstrb   = '0;
    assign out_axis_if.twakeup = 1'b0;

    assign status_depth        = wr_ptr_q - head_ptr;
    assign status_frame_count  = frame_cnt_q;
    assign status_almost_full  = run_q && (status_depth >= AfLevel);
    assign status_almost_empty = run_q && (status_depth <= AeLevel);

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench: streaming mode via a per-cycle vector table, frame mode via hand sequences.
module tb_axis_frame_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sel = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       s_user = 1'b0;
    logic       m_ready = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    AXIS_IF #(.DATA_W(8), .ID_W(4), .DEST_W(4), .USER_W(1)) in0 ();
    AXIS_IF #(.DATA_W(8), .ID_W(4), .DEST_W(4), .USER_W(1)) out0 ();
    AXIS_IF #(.DATA_W(8), .ID_W(4), .DEST_W(4), .USER_W(1)) in1 ();
    AXIS_IF #(.DATA_W(8), .ID_W(4), .DEST_W(4), .USER_W(1)) out1 ();

    assign in0.tvalid = s_valid;  assign in1.tvalid = s_valid;
    assign in0.tdata  = s_data;   assign in1.tdata  = s_data;
    assign in0.tkeep  = 1'b1;     assign in1.tkeep  = 1'b1;
    assign in0.tstrb  = 1'b0;     assign in1.tstrb  = 1'b0;
    assign in0.tlast  = s_last;   assign in1.tlast  = s_last;
    assign in0.tid    = '0;       assign in1.tid    = '0;
    assign in0.tdest  = '0;       assign in1.tdest  = '0;
    assign in0.tuser  = s_user;   assign in1.tuser  = s_user;
    assign in0.twakeup = 1'b0;    assign in1.twakeup = 1'b0;
    assign out0.tready = m_ready; assign out1.tready = m_ready;

    logic [4:0] depth0, depth1, fc0, fc1;
    logic af0, af1, ae0, ae1, ov0, ov1, bad0, bad1, good0, good1;

    axis_frame_fifo #(
        .DEPTH      (16),
        .FRAME_FIFO (1'b0)
    ) dut0 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_axis_if          (in0),
        .out_axis_if         (out0),
        .status_depth        (depth0),
        .status_frame_count  (fc0),
        .status_almost_full  (af0),
        .status_almost_empty (ae0),
        .status_overflow     (ov0),
        .status_bad_frame    (bad0),
        .status_good_frame   (good0)
    );

    axis_frame_fifo #(
        .DEPTH          (16),
        .FRAME_FIFO     (1'b1),
        .DROP_BAD_FRAME (1'b1)
    ) dut1 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_axis_if          (in1),
        .out_axis_if         (out1),
        .status_depth        (depth1),
        .status_frame_count  (fc1),
        .status_almost_full  (af1),
        .status_almost_empty (ae1),
        .status_overflow     (ov1),
        .status_bad_frame    (bad1),
        .status_good_frame   (good1)
    );

    // Both DUTs see the same input stream; sel picks which one is observed.
    logic       c_tready, c_ovalid, c_olast, c_af, c_ae, c_ov, c_bad, c_good;
    logic [7:0] c_odata;
    logic [4:0] c_depth, c_fc;
    assign c_tready = sel ? in1.tready  : in0.tready;
    assign c_ovalid = sel ? out1.tvalid : out0.tvalid;
    assign c_olast  = sel ? out1.tlast  : out0.tlast;
    assign c_odata  = sel ? out1.tdata  : out0.tdata;
    assign c_depth  = sel ? depth1 : depth0;
    assign c_fc     = sel ? fc1 : fc0;
    assign c_af     = sel ? af1 : af0;
    assign c_ae     = sel ? ae1 : ae0;
    assign c_ov     = sel ? ov1 : ov0;
    assign c_bad    = sel ? bad1 : bad0;
    assign c_good   = sel ? good1 : good0;

    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];

    always @(negedge clk) begin
        if (reset_n && c_ovalid && m_ready) rx_q.push_back({c_olast, c_odata});
    end

    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         last;
        bit         ready;
        bit         e_tready;
        int         e_depth;
        int         e_fcount;
        bit         e_ovalid;
        logic [7:0] e_odata;
    } vec_t;

    vec_t vecs[34];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rx(input string nm);
        chk({nm, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", nm, i), int'(rx_q[i]), int'(exp_q[i]));
        end
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        rx_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [7:0] d, input bit last, input bit user,
                        output bit ov, output bit bad, output bit good);
        bit done;
        done = 1'b0;
        ov = 1'b0; bad = 1'b0; good = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = last; s_user = user;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (c_tready) begin
                done = 1'b1; ov = c_ov; bad = c_bad; good = c_good;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: beat %0h not accepted, required acceptance", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ov, bad, good;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(8'hA0 + i), (i % 4) == 3, 1'b0, 1'b1, i, i / 4, i >= 2, 8'hA0};
        end
        vecs[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16, 4, 1'b1, 8'hA0};
        for (int k = 0; k < 16; k++) begin
            vecs[17 + k] = '{1'b0, 8'h00, 1'b0, 1'b1, k != 0, 16 - k, 4 - k / 4, 1'b1,
                             8'(8'hA0 + k)};
        end
        vecs[33] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00};

        // Reset state while reset_n is held low.
        #2;
        chk("rst_tready", c_tready, 0);
        chk("rst_ovalid", c_ovalid, 0);
        chk("rst_depth", c_depth, 0);
        chk("rst_almost_empty", c_ae, 0);

        // Streaming mode: fill to 16, stall, then drain in order.
        sel = 1'b0;
        reset_dut();
        for (int r = 0; r < 34; r++) begin
            s_valid = vecs[r].valid; s_data = vecs[r].data; s_last = vecs[r].last;
            m_ready = vecs[r].ready;
            @(negedge clk);
            chk($sformatf("v%0d_tready", r), c_tready, vecs[r].e_tready);
            chk($sformatf("v%0d_depth", r), c_depth, vecs[r].e_depth);
            chk($sformatf("v%0d_fcount", r), c_fc, vecs[r].e_fcount);
            chk($sformatf("v%0d_ovalid", r), c_ovalid, vecs[r].e_ovalid);
            chk($sformatf("v%0d_afull", r), c_af, vecs[r].e_depth >= 12);
            chk($sformatf("v%0d_aempty", r), c_ae, vecs[r].e_depth <= 4);
            if (vecs[r].e_ovalid) chk($sformatf("v%0d_odata", r), c_odata, vecs[r].e_odata);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("tstrb_zero", out0.tstrb, 0);
        chk("twakeup_zero", out0.twakeup, 0);

        // Frame mode: 3-beat frame stays invisible until one cycle after tlast.
        sel = 1'b1;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            send(8'(8'h11 + i), i == 2, 1'b0, ov, bad, good);
            chk($sformatf("f3_good%0d", i), good, i == 2);
            chk($sformatf("f3_ovalid%0d", i), c_ovalid, 0);
        end
        @(negedge clk);
        chk("f3_fcount", c_fc, 1);
        chk("f3_depth", c_depth, 3);
        @(posedge clk);
        #1;
        chk("f3_ovalid_late", c_ovalid, 1);
        chk("f3_odata", c_odata, 8'h11);
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        exp_q = '{9'h011, 9'h012, 9'h113};
        chk_rx("f3_rx");
        chk("f3_fcount_after", c_fc, 0);

        // Oversize 20-beat frame is swallowed with overflow on its tlast.
        reset_dut();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(8'(i), i == 19, 1'b0, ov, bad, good);
            chk($sformatf("big_ov%0d", i), ov, i == 19);
            if (i == 15) chk("big_depth16", c_depth, 16);
            if (i == 19) chk("big_good", good, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("big_depth_end", c_depth, 0);
        chk("big_fcount", c_fc, 0);
        exp_q.delete();
        chk_rx("big_rx");

        // Bad frame is rewound, the following good frame is delivered intact.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h21 + i), i == 3, i == 3, ov, bad, good);
            chk($sformatf("bad_pulse%0d", i), bad, i == 3);
            chk($sformatf("bad_good%0d", i), good, 0);
        end
        chk("bad_depth", c_depth, 0);
        send(8'h31, 1'b0, 1'b0, ov, bad, good);
        send(8'h32, 1'b1, 1'b0, ov, bad, good);
        chk("good_after_bad", good, 1);
        m_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        exp_q = '{9'h031, 9'h132};
        chk_rx("bad_rx");

        // Reset in the middle of a frame.
        reset_dut();
        send(8'h41, 1'b0, 1'b0, ov, bad, good);
        send(8'h42, 1'b0, 1'b0, ov, bad, good);
        chk("mid_depth_pre", c_depth, 2);
        reset_n = 1'b0;
        rx_q.delete();
        #1;
        chk("mid_rst_tready", c_tready, 0);
        chk("mid_rst_depth", c_depth, 0);
        chk("mid_rst_ovalid", c_ovalid, 0);
        chk("mid_rst_fcount", c_fc, 0);
        chk("mid_rst_aempty", c_ae, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("mid_tready_before_edge", c_tready, 0);
        @(posedge clk);
        #1;
        chk("mid_tready_after_edge", c_tready, 1);
        send(8'h51, 1'b0, 1'b0, ov, bad, good);
        send(8'h52, 1'b1, 1'b0, ov, bad, good);
        chk("mid_good", good, 1);
        chk("mid_ovalid_early", c_ovalid, 0);
        @(posedge clk);
        #1;
        chk("mid_ovalid_late", c_ovalid, 1);
        chk("mid_odata", c_odata, 8'h51);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q = '{9'h051, 9'h152};
        chk_rx("mid_rx");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
